// File: rtl/prf_wb_arb_pkg.sv
// prf_wb_arb_pkg: shared sizes, zero-register tag, requester names and writeback payload type
package prf_wb_arb_pkg;
  localparam int PRF_NUM = 64;
  localparam int PRF_IDX_W = $clog2(PRF_NUM);
  localparam int WB_DATA_W = 64;
  localparam int WB_N_REQ = 4;
  localparam logic [PRF_IDX_W-1:0] ZERO_REG = '0;
  typedef enum logic [1:0] {WB_ALU0, WB_ALU1, WB_MULT, WB_LSQ} wb_src_e;
  typedef struct packed {
    logic [PRF_IDX_W-1:0] idx;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/prf_wb_arb_if.sv
// prf_wb_arb_if: FU writeback requests in, PRF write port and CDB broadcast out
interface prf_wb_arb_if
  import prf_wb_arb_pkg::*;
#(
  parameter int N_REQ = WB_N_REQ,
  parameter int DATA_W = WB_DATA_W,
  parameter int IDX_W = PRF_IDX_W
) ();
  logic squash_i;
  logic [N_REQ-1:0] fu_valid_i;
  logic [N_REQ-1:0][IDX_W-1:0] fu_idx_i;
  logic [N_REQ-1:0][DATA_W-1:0] fu_data_i;
  logic [N_REQ-1:0] fu_ready_o;
  logic prf_wr_en_o;
  logic [IDX_W-1:0] prf_wr_idx_o;
  logic [DATA_W-1:0] prf_wr_data_o;
  logic cdb_valid_o;
  logic [IDX_W-1:0] cdb_tag_o;
  modport master (
    output squash_i, fu_valid_i, fu_idx_i, fu_data_i,
    input fu_ready_o, prf_wr_en_o, prf_wr_idx_o, prf_wr_data_o, cdb_valid_o, cdb_tag_o
  );
  modport slave (
    input squash_i, fu_valid_i, fu_idx_i, fu_data_i,
    output fu_ready_o, prf_wr_en_o, prf_wr_idx_o, prf_wr_data_o, cdb_valid_o, cdb_tag_o
  );
endinterface

// File: rtl/prf_wb_arb_rr_arb.sv
// prf_wb_arb_rr_arb: combinational rotate-priority picker, first request at or after ptr wins
module prf_wb_arb_rr_arb #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);
  logic [PW-1:0] j;
  // scan from farthest to nearest offset so the nearest request overwrites
  always_comb begin
    j = '0;
    gnt_idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % N);
      if (req[j]) begin
        gnt_idx = j;
        any = 1'b1;
      end
    end
    gnt = any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/prf_wb_arb.sv
// prf_wb_arb: round-robin share of the PRF write port among FU writeback requesters
module prf_wb_arb
  import prf_wb_arb_pkg::*;
#(
  parameter int N_REQ = WB_N_REQ,
  parameter int DATA_W = WB_DATA_W,
  parameter int IDX_W = PRF_IDX_W
) (
  input logic clk,
  input logic rst_n,
  prf_wb_arb_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0] zr, live, gnt;
  logic [PW-1:0] gnt_idx, rr_ptr_d, rr_ptr_q;
  logic any, take;
  logic wr_en_d, wr_en_q;
  logic [IDX_W-1:0] wr_idx_d, wr_idx_q;
  logic [DATA_W-1:0] wr_data_d, wr_data_q;
  // zero-register results are acked directly and never compete for the port
  always_comb begin
    zr = '0;
    for (int i = 0; i < N_REQ; i++) zr[i] = bus.fu_valid_i[i] && (bus.fu_idx_i[i] == IDX_W'(ZERO_REG));
    live = bus.fu_valid_i & ~zr;
  end
  prf_wb_arb_rr_arb #(.N(N_REQ)) u_rr (
    .req(live),
    .ptr(rr_ptr_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .any(any)
  );
  // squash blocks every acceptance and empties the output stage; idx/data hold when idle
  always_comb begin
    take = any && !bus.squash_i;
    rr_ptr_d = take ? ((gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
    wr_en_d = take;
    wr_idx_d = take ? bus.fu_idx_i[gnt_idx] : wr_idx_q;
    wr_data_d = take ? bus.fu_data_i[gnt_idx] : wr_data_q;
    bus.fu_ready_o = (rst_n && !bus.squash_i) ? (gnt | zr) : '0;
  end
  // pointer and registered write/broadcast stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      wr_en_q <= 1'b0;
      wr_idx_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_en_q <= wr_en_d;
      wr_idx_q <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign bus.prf_wr_en_o = wr_en_q;
  assign bus.prf_wr_idx_o = wr_idx_q;
  assign bus.prf_wr_data_o = wr_data_q;
  assign bus.cdb_valid_o = wr_en_q;
  assign bus.cdb_tag_o = wr_idx_q;
endmodule
